// File: rtl/vga_screen_sequencer.sv
// vga_screen_sequencer: frame-synchronous RGB source selector placed between
// the display_controller timing outputs and the VGA pins.
// Source switches take effect only at frame boundaries, so there is no tearing.
// A timed banner screen and a sticky terminal screen sit on top of normal play.
// Optional build macro: VGA_SEQ_FADE_EN adds a fade-in from black after every
// source change.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_NORMAL  | normal play; src_sel_req picks the source at each frame start
// ST_BANNER  | banner source shown for BANNER_FRAMES frames
// ST_STICKY  | terminal screen; only reset leaves this state
module vga_screen_sequencer #(
  parameter int NUM_SRC       = 4,
  parameter int COLOR_W       = 4,
  parameter int BANNER_SRC    = 1,
  parameter int BANNER_FRAMES = 120,
  localparam int SEL_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int RGB_W        = 3 * COLOR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bright,
  input  logic                     hSync_in,
  input  logic                     vSync_in,
  input  logic [NUM_SRC*RGB_W-1:0] src_rgb,
  input  logic [SEL_W-1:0]         src_sel_req,
  input  logic                     banner_req,
  input  logic                     sticky_req,
  input  logic [SEL_W-1:0]         sticky_sel,
  output logic [RGB_W-1:0]         rgb_out,
  output logic                     hSync_out,
  output logic                     vSync_out,
  output logic [SEL_W-1:0]         active_src,
  output logic                     banner_active,
  output logic                     sticky_flag
);

  // Counter only ever holds BANNER_FRAMES-1 down to 0.
  localparam int CNT_W = (BANNER_FRAMES > 1) ? $clog2(BANNER_FRAMES) : 1;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_BANNER = 2'd1,
    ST_STICKY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   active_q, active_d;
  logic [SEL_W-1:0]   norm_sel_q, norm_sel_d;
  logic [SEL_W-1:0]   sticky_idx_q, sticky_idx_d;
  logic               banner_pend_q, banner_pend_d;
  logic               sticky_pend_q, sticky_pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_tick_q;
  logic               sel_ok;
  logic               sticky_ok;
  logic [RGB_W-1:0]   sel_rgb;
  logic [RGB_W-1:0]   pix_rgb;

  assign sel_ok        = (32'(src_sel_req) < NUM_SRC);
  assign sticky_ok     = (32'(sticky_idx_q) < NUM_SRC);
  assign active_src    = active_q;
  assign banner_active = (state_q == ST_BANNER);
  assign sticky_flag   = (state_q == ST_STICKY);

  // Control register bank: FSM state, selection, pending requests, banner counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_NORMAL;
      active_q      <= '0;
      norm_sel_q    <= '0;
      sticky_idx_q  <= '0;
      banner_pend_q <= 1'b0;
      sticky_pend_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      norm_sel_q    <= norm_sel_d;
      sticky_idx_q  <= sticky_idx_d;
      banner_pend_q <= banner_pend_d;
      sticky_pend_q <= sticky_pend_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state logic; every decision waits for frame_tick so screens never tear.
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    norm_sel_d    = norm_sel_q;
    cnt_d         = cnt_q;
    banner_pend_d = banner_pend_q | banner_req;
    sticky_pend_d = sticky_pend_q | sticky_req;
    sticky_idx_d  = sticky_req ? sticky_sel : sticky_idx_q;
    if (frame_tick_q) begin
      // Pending flags are consumed here; a request landing on the tick itself
      // is kept for the following frame.
      banner_pend_d = banner_req;
      sticky_pend_d = sticky_req;
      case (state_q)
        ST_NORMAL: begin
          if (sticky_pend_q) begin
            state_d  = ST_STICKY;
            active_d = sticky_ok ? sticky_idx_q : '0;
          end else if (banner_pend_q && (BANNER_FRAMES > 0)) begin
            state_d  = ST_BANNER;
            active_d = SEL_W'(BANNER_SRC);
            cnt_d    = CNT_W'(BANNER_FRAMES - 1);
          end else if (sel_ok) begin
            active_d   = src_sel_req;
            norm_sel_d = src_sel_req;
          end
        end
        ST_BANNER: begin
          if (sticky_pend_q) begin
            state_d  = ST_STICKY;
            active_d = sticky_ok ? sticky_idx_q : '0;
          end else if (banner_pend_q) begin
            cnt_d = CNT_W'(BANNER_FRAMES - 1);
          end else if (cnt_q == '0) begin
            state_d = ST_NORMAL;
            if (sel_ok) begin
              active_d   = src_sel_req;
              norm_sel_d = src_sel_req;
            end else begin
              active_d = norm_sel_q;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_STICKY: begin
          state_d = ST_STICKY;
        end
        default: begin
          state_d  = ST_NORMAL;
          active_d = '0;
        end
      endcase
    end
  end

  // Source mux: pick the packed RGB word of the displayed source.
  always_comb begin
    sel_rgb = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_q == SEL_W'(i)) sel_rgb = src_rgb[i*RGB_W +: RGB_W];
    end
  end

`ifdef VGA_SEQ_FADE_EN
  localparam int FADE_W = $clog2(COLOR_W + 1);

  logic [FADE_W-1:0] fade_q, fade_d;

  // Fade counter restarts on any source change and counts down once per frame.
  always_comb begin
    fade_d = fade_q;
    if (active_d != active_q) begin
      fade_d = FADE_W'(COLOR_W);
    end else if (frame_tick_q && (fade_q != '0)) begin
      fade_d = fade_q - FADE_W'(1);
    end
  end

  // Fade counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fade_q <= '0;
    else       fade_q <= fade_d;
  end

  // Each channel dimmed independently by the current fade shift.
  always_comb begin
    pix_rgb = '0;
    for (int c = 0; c < 3; c++) begin
      pix_rgb[c*COLOR_W +: COLOR_W] = sel_rgb[c*COLOR_W +: COLOR_W] >> fade_q;
    end
  end
`else
  assign pix_rgb = sel_rgb;
`endif

  // Pixel/sync stage: one register for colour and syncs keeps them aligned;
  // the registered vSync doubles as the previous sample for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out      <= '0;
      hSync_out    <= 1'b1;
      vSync_out    <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      rgb_out      <= bright ? pix_rgb : '0;
      hSync_out    <= hSync_in;
      vSync_out    <= vSync_in;
      frame_tick_q <= vSync_out & ~vSync_in;
    end
  end

endmodule
